// File: rtl/ufp_line_buffer.sv
// Single-line memory responder: answers word requests from one cached line,
// fills the line from a line-wide downstream port on a miss, and writes through.
module ufp_line_buffer #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               ufp_addr,
    input  logic [3:0]                ufp_rmask,
    input  logic [3:0]                ufp_wmask,
    input  logic [31:0]               ufp_wdata,
    output logic [31:0]               ufp_rdata,
    output logic                      ufp_resp,
    output logic [31:0]               dfp_addr,
    output logic                      dfp_read,
    output logic                      dfp_write,
    output logic [32*LINE_WORDS-1:0]  dfp_wdata,
    input  logic [32*LINE_WORDS-1:0]  dfp_rdata,
    input  logic                      dfp_resp
);

    localparam int unsigned OFF   = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX_W = OFF - 2;
    localparam int unsigned TAG_W = 32 - OFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WBACK = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
    logic [TAG_W-1:0]             tag_q, tag_d;
    logic                         valid_q, valid_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic                         resp_q, resp_d;
    logic [31:0]                  dfp_addr_q, dfp_addr_d;
    logic                         dfp_read_q, dfp_read_d;
    logic                         dfp_write_q, dfp_write_d;

    logic [LINE_WORDS-1:0][31:0]  fill_line;
    logic [TAG_W-1:0]             req_tag;
    logic [IDX_W-1:0]             req_idx;
    logic                         req_wr;
    logic                         req_rd;
    logic                         hit;
    logic [31:0]                  line_addr;
    logic                         unused_addr_bits;

    assign fill_line        = dfp_rdata;
    assign req_tag          = ufp_addr[31:OFF];
    assign req_idx          = ufp_addr[OFF-1:2];
    assign req_wr           = |ufp_wmask;
    assign req_rd           = |ufp_rmask;
    assign hit              = valid_q && (tag_q == req_tag);
    assign line_addr        = {req_tag, {OFF{1'b0}}};
    assign unused_addr_bits = ^ufp_addr[1:0];

    // Byte-wise merge of write data into an existing word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wmask);
        logic [31:0] res;
        res = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wmask[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        resp_d      = 1'b0;
        dfp_addr_d  = dfp_addr_q;
        dfp_read_d  = dfp_read_q;
        dfp_write_d = dfp_write_q;

        unique case (state_q)
            IDLE: begin
                if (req_wr || req_rd) begin
                    if (!hit) begin
                        dfp_addr_d = line_addr;
                        dfp_read_d = 1'b1;
                        state_d    = FILL;
                    end else if (req_wr) begin
                        line_d[req_idx] = merge_word(line_q[req_idx], ufp_wdata, ufp_wmask);
                        rdata_d         = line_q[req_idx];
                        dfp_addr_d      = line_addr;
                        dfp_write_d     = 1'b1;
                        state_d         = WBACK;
                    end else begin
                        rdata_d = line_q[req_idx];
                        resp_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            FILL: begin
                if (dfp_resp) begin
                    line_d     = fill_line;
                    tag_d      = req_tag;
                    valid_d    = 1'b1;
                    dfp_read_d = 1'b0;
                    rdata_d    = fill_line[req_idx];
                    if (req_wr) begin
                        // Merge at the fill edge so the write-back carries the updated line.
                        line_d[req_idx] = merge_word(fill_line[req_idx], ufp_wdata, ufp_wmask);
                        dfp_write_d     = 1'b1;
                        state_d         = WBACK;
                    end else begin
                        resp_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WBACK: begin
                if (dfp_resp) begin
                    dfp_write_d = 1'b0;
                    resp_d      = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Requester still shows the completed request here; ignore it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= 1'b0;
            dfp_addr_q  <= '0;
            dfp_read_q  <= 1'b0;
            dfp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            dfp_addr_q  <= dfp_addr_d;
            dfp_read_q  <= dfp_read_d;
            dfp_write_q <= dfp_write_d;
        end
    end

    assign ufp_rdata = rdata_q;
    assign ufp_resp  = resp_q;
    assign dfp_addr  = dfp_addr_q;
    assign dfp_read  = dfp_read_q;
    assign dfp_write = dfp_write_q;
    assign dfp_wdata = line_q;

endmodule

// File: doc/ufp_line_buffer.md
# ufp_line_buffer

Single-line memory responder serving the word-wide `ufp_*` request port that the fetch unit and other cores drive. It holds one cached line and answers hits from that line. On a miss it fills the line from a line-wide downstream port (`dfp_*`). Writes are merged into the line and written through downstream before they are acknowledged.

## Interface
- `LINE_WORDS`, default 8: number of 32-bit words per line.
  - Line = `32*LINE_WORDS` bits.
  - `OFF = log2(LINE_WORDS)+2` is the number of offset bits.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `ufp_addr`, input, 32: request byte address; bits [1:0] are ignored.
- `ufp_rmask`, input, 4: read byte mask; nonzero means read request.
- `ufp_wmask`, input, 4: write byte mask; nonzero means write request, and it takes priority over `ufp_rmask`.
- `ufp_wdata`, input, 32: write data.
- `ufp_rdata`, output, 32: read data, valid while `ufp_resp`=1.
- `ufp_resp`, output, 1: one-cycle completion pulse.
- `dfp_addr`, output, 32: line address; bits [OFF-1:0] are always 0.
- `dfp_read`, output, 1: line read request, held until `dfp_resp`.
- `dfp_write`, output, 1: line write request, held until `dfp_resp`.
- `dfp_wdata`, output, `32*LINE_WORDS`: line write data, equal to the buffer contents.
- `dfp_rdata`, input, `32*LINE_WORDS`: fill data, sampled on `dfp_resp`.
- `dfp_resp`, input, 1: downstream completion pulse.

## Operation
- Storage:
  - `line_r` (data), `tag_r` (`addr[31:OFF]`), `valid_r`.
  - Word select is `addr[OFF-1:2]`.
- Request protocol: the requester holds addr/masks/wdata stable from the first cycle of a request until the cycle `ufp_resp`=1. The block samples the request only in IDLE.
- Hit condition: `valid_r && tag_r == ufp_addr[31:OFF]`.
- FSM states: IDLE, FILL, WBACK, RESP.
  - IDLE, no request (both masks 0): stay in IDLE.
  - IDLE, read hit:
    - Register `ufp_rdata` = selected word.
    - Go to RESP.
  - IDLE, read or write miss:
    - Register `dfp_addr` = `{ufp_addr[31:OFF], OFF'b0}` and set `dfp_read`.
    - Go to FILL.
  - IDLE, write hit:
    - Merge `ufp_wdata` into the selected word per `ufp_wmask` bytes.
    - Set `dfp_addr` to the line address and set `dfp_write`.
    - Register `ufp_rdata` = the pre-merge word.
    - Go to WBACK.
  - FILL, on `dfp_resp`:
    - `line_r` = `dfp_rdata`, `tag_r` = request tag, `valid_r` = 1, drop `dfp_read`.
    - For a read: `ufp_rdata` = filled word, go to RESP.
    - For a write: merge `ufp_wdata` into the filled line at the same edge, set `dfp_write`, go to WBACK.
  - WBACK, on `dfp_resp`: drop `dfp_write`, go to RESP.
  - RESP:
    - `ufp_resp`=1 for exactly one cycle.
    - Request inputs are ignored in this cycle, because the requester still shows the old request.
    - Return to IDLE.
- `ufp_rmask` contents beyond zero/nonzero do not matter: the full 32-bit word is always returned.
- `dfp_read` and `dfp_write` are never asserted together.
- `dfp_resp` outside FILL/WBACK is ignored.
- Reset (asynchronous, may occur in any state):
  - State goes to IDLE.
  - `valid_r`=0, `line_r`=0, `tag_r`=0.
  - All registered outputs go to 0 immediately, without waiting for a clock edge.
  - An in-flight downstream transaction is abandoned.

## Timing
- Reset values: `ufp_resp`=0, `ufp_rdata`=0, `dfp_read`=0, `dfp_write`=0, `dfp_addr`=0, `dfp_wdata`=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Read hit:
  - Request seen in IDLE at cycle N.
  - `ufp_resp`=1 at N+1.
  - Next request can be sampled at N+2, so hit throughput is 1 request per 2 cycles.
- Miss:
  - Request seen at N; `dfp_read`=1 from N+1.
  - `dfp_resp` arrives at cycle M.
  - Read: `ufp_resp` at M+1.
  - Write: `dfp_write`=1 from M+1; `dfp_resp` arrives at K; `ufp_resp` at K+1.
- Write hit: request at N, `dfp_write`=1 from N+1, `dfp_resp` at K, `ufp_resp` at K+1.
- `dfp_addr` and `dfp_wdata` are stable for the whole time `dfp_read` or `dfp_write` is high.

## Test plan
- **Reset:** assert `rst` for 2 cycles.
  - All outputs are 0 while `rst`=1.
  - After release, a read of 0x1ECEB000 misses, with `dfp_addr`=0x1ECEB000.
- **Read miss, then hit:**
  - Stimulus: read 0x1ECEB004. Word1 of the fill line = 0x00000013, `dfp_resp` returned 3 cycles after `dfp_read` rises.
  - Response: `ufp_resp` comes 1 cycle after `dfp_resp`, with `ufp_rdata`=0x00000013.
  - Follow-up: read 0x1ECEB008 gives `ufp_resp` at N+1 with no `dfp_read`.
- **Write hit:**
  - Stimulus: line holds word1=0x00000013; write 0x1ECEB004 with `wmask`=4'b0011, `wdata`=0xAAAA5555.
  - `dfp_write`=1 with `dfp_addr`=0x1ECEB000 and `dfp_wdata` word1=0x00005555.
  - `ufp_resp` comes 1 cycle after `dfp_resp`.
  - A subsequent read of 0x1ECEB004 returns 0x00005555.
- **Write miss:**
  - Stimulus: write 0x1ECEB020 with `wmask`=4'b1000, `wdata`=0xFF000000, against a fill word0 of 0x12345678.
  - `dfp_read` is issued first, then `dfp_write` with word0=0xFF345678.
  - Exactly one `ufp_resp`.
- **Back-to-back held request:**
  - Stimulus: requester holds a read of 0x1ECEB00C through the `ufp_resp` cycle, then switches to 0x1ECEB010.
  - Exactly one `ufp_resp` per address.
  - No duplicate response for 0x1ECEB00C.
- **Reset mid-FILL:**
  - Stimulus: assert `rst` while `dfp_read`=1, then release.
  - `dfp_read` drops immediately.
  - The line is invalid after release: a repeat read of the same address misses again.
